// File: rtl/seg_display_driver_pkg.sv
// ============================================================================
// Module : seg_display_driver_pkg
// Brief  : Shared widths, 7-segment codes and enums for the display driver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seg_display_driver_pkg;

    localparam int DATA_W     = 6;
    localparam int NUM_DIGITS = 3;
    localparam int BCD_W      = 4;

    // Codes are {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        DIG_UNITS = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_SIGN  = 2'd2
    } digit_sel_t;

    typedef enum logic [1:0] {
        CONV_IDLE   = 2'd0,
        CONV_SHIFT  = 2'd1,
        CONV_COMMIT = 2'd2
    } conv_state_t;

    function automatic logic [6:0] digit_to_seg(input logic [BCD_W-1:0] d);
        logic [6:0] code;
        code = SEG_BLANK;
        if (d <= 4'd9) begin
            code = SEG_DIGIT[d];
        end
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_display_driver_if.sv
// ============================================================================
// Module : seg_display_driver_if
// Brief  : Load/blank request side and 7-segment output bus of the driver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface seg_display_driver_if;
    import seg_display_driver_pkg::*;

    logic [DATA_W-1:0]     value;
    logic                  load;
    logic                  blank;
    logic                  busy;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;

    modport master (
        output value, load, blank,
        input  busy, seg, an
    );

    modport slave (
        input  value, load, blank,
        output busy, seg, an
    );

endinterface

`default_nettype wire

// File: rtl/seg_display_driver_bcd.sv
// ============================================================================
// Module : seg_display_driver_bcd
// Brief  : Sequential double-dabble, one magnitude bit per cycle, then COMMIT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg_display_driver_bcd
    import seg_display_driver_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start_i,
    input  wire logic [DATA_W-1:0] mag_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [BCD_W-1:0]       tens_o,
    output logic [BCD_W-1:0]       units_o
);

    localparam logic [2:0] C_LAST_SHIFT = 3'(DATA_W - 1);

    conv_state_t       state_q, state_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  tens_q, tens_d;
    logic [BCD_W-1:0]  units_q, units_d;
    logic [2:0]        cnt_q, cnt_d;

    logic [BCD_W-1:0]  tens_adj;
    logic [BCD_W-1:0]  units_adj;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CONV_IDLE;
            bin_q   <= '0;
            tens_q  <= '0;
            units_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            cnt_q   <= cnt_d;
        end
    end

    // Nibbles are corrected before the shift so they never exceed 9 afterwards.
    always_comb begin
        tens_adj  = (tens_q  >= 4'd5) ? tens_q  + 4'd3 : tens_q;
        units_adj = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;

        state_d = state_q;
        bin_d   = bin_q;
        tens_d  = tens_q;
        units_d = units_q;
        cnt_d   = cnt_q;

        case (state_q)
            CONV_IDLE: begin
                if (start_i) begin
                    bin_d   = mag_i;
                    tens_d  = '0;
                    units_d = '0;
                    cnt_d   = '0;
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                tens_d  = {tens_adj[2:0], units_adj[3]};
                units_d = {units_adj[2:0], bin_q[DATA_W-1]};
                bin_d   = {bin_q[DATA_W-2:0], 1'b0};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == C_LAST_SHIFT) begin
                    state_d = CONV_COMMIT;
                end
            end
            CONV_COMMIT: begin
                state_d = CONV_IDLE;
            end
            default: begin
                state_d = CONV_IDLE;
            end
        endcase
    end

    assign busy_o  = (state_q != CONV_IDLE);
    assign done_o  = (state_q == CONV_COMMIT);
    assign tens_o  = tens_q;
    assign units_o = units_q;

endmodule

`default_nettype wire

// File: rtl/seg_display_driver.sv
// ============================================================================
// Module : seg_display_driver
// Brief  : Captures a signed result, converts to BCD and scans 3 digits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg_display_driver
    import seg_display_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
) (
    input  wire logic            clk,
    input  wire logic            reset,
    seg_display_driver_if.slave  bus
);

    localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_TC = CNT_W'(REFRESH_DIV - 1);

    logic                  conv_busy;
    logic                  conv_done;
    logic [BCD_W-1:0]      conv_tens;
    logic [BCD_W-1:0]      conv_units;
    logic                  accept;
    logic [DATA_W-1:0]     mag;

    logic                  sign_pend_q, sign_pend_d;
    logic                  sign_q, sign_d;
    logic [BCD_W-1:0]      tens_q, tens_d;
    logic [BCD_W-1:0]      units_q, units_d;
    logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
    digit_sel_t            dig_q, dig_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    assign accept = bus.load & ~conv_busy;
    // -32 negates to 6'b100000, which reads correctly as unsigned 32.
    assign mag    = bus.value[DATA_W-1] ? (~bus.value + 6'd1) : bus.value;

    seg_display_driver_bcd u_bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept),
        .mag_i   (mag),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .tens_o  (conv_tens),
        .units_o (conv_units)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_pend_q <= 1'b0;
            sign_q      <= 1'b0;
            tens_q      <= '0;
            units_q     <= '0;
            scan_cnt_q  <= '0;
            dig_q       <= DIG_UNITS;
            seg_q       <= SEG_BLANK;
            an_q        <= '1;
        end else begin
            sign_pend_q <= sign_pend_d;
            sign_q      <= sign_d;
            tens_q      <= tens_d;
            units_q     <= units_d;
            scan_cnt_q  <= scan_cnt_d;
            dig_q       <= dig_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    always_comb begin
        sign_pend_d = accept ? bus.value[DATA_W-1] : sign_pend_q;
        sign_d      = sign_q;
        tens_d      = tens_q;
        units_d     = units_q;
        if (conv_done) begin
            sign_d  = sign_pend_q;
            tens_d  = conv_tens;
            units_d = conv_units;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        dig_d      = dig_q;
        if (scan_cnt_q == C_CNT_TC) begin
            scan_cnt_d = '0;
            case (dig_q)
                DIG_UNITS: dig_d = DIG_TENS;
                DIG_TENS:  dig_d = DIG_SIGN;
                default:   dig_d = DIG_UNITS;
            endcase
        end
    end

    // Tens suppresses a leading zero; a minus is never shown for zero.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        case (dig_q)
            DIG_UNITS: begin
                seg_d = digit_to_seg(units_q);
                an_d  = 3'b110;
            end
            DIG_TENS: begin
                seg_d = (tens_q == '0) ? SEG_BLANK : digit_to_seg(tens_q);
                an_d  = 3'b101;
            end
            DIG_SIGN: begin
                seg_d = (sign_q && ((tens_q != '0) || (units_q != '0))) ? SEG_MINUS : SEG_BLANK;
                an_d  = 3'b011;
            end
            default: begin
                seg_d = SEG_BLANK;
                an_d  = '1;
            end
        endcase
        if (bus.blank) begin
            an_d = '1;
        end
    end

    assign bus.busy = conv_busy;
    assign bus.seg  = seg_q;
    assign bus.an   = an_q;

endmodule

`default_nettype wire
